// File: rtl/riscv_rf_pkg.sv
// Shared constants and types for the parametrised RISC-V register file.
// Holds the default geometry and the x0 index used by the datapath.
package riscv_rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned REG_AW   = $clog2(NREG_DEF);

  typedef logic [REG_AW-1:0] reg_idx_t;

  // x0 is hardwired to zero and can never hold an outstanding producer
  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus between decode/writeback and the register file with busy-bit scoreboard.
// No valid/ready handshake: reg_wr, iss_valid and flush are single-cycle strobes sampled every edge, and the read side is purely combinational, so there is no backpressure.
interface reg_file_sb_if #(
  parameter int unsigned XLEN = riscv_rf_pkg::XLEN_DEF,
  parameter int unsigned NREG = riscv_rf_pkg::NREG_DEF,
  parameter int unsigned NRP  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic                     reg_wr;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic [NRP-1:0][AW-1:0]   raddr;
  logic [NRP-1:0][XLEN-1:0] rdata;
  logic [NRP-1:0]           rd_busy;
  logic                     hazard;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     flush;

  modport master (
    output reg_wr, waddr, wdata, raddr, iss_valid, iss_rd, flush,
    input  rdata, rd_busy, hazard
  );

  modport slave (
    input  reg_wr, waddr, wdata, raddr, iss_valid, iss_rd, flush,
    output rdata, rd_busy, hazard
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, wiped on flush.
// Also produces the per-read-port busy view used by decode for RAW detection.
module rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned NRP    = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_wr,
  input  logic [AW-1:0]          waddr,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   flush,
  input  logic [NRP-1:0][AW-1:0] raddr,
  output logic [NRP-1:0]         rd_busy
);

  localparam logic [AW-1:0] X0 = AW'(X0_IDX);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Issue is applied after writeback so a same-cycle set of the same register wins
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (reg_wr)    busy_d[waddr]  = 1'b0;
      if (iss_valid) busy_d[iss_rd] = 1'b1;
    end
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A port being fed by the bypass path is not stalled, its value arrives now
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      if (raddr[p] == X0) begin
        rd_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && reg_wr && (waddr == raddr[p])) begin
        rd_busy[p] = 1'b0;
      end else begin
        rd_busy[p] = busy_q[raddr[p]];
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with optional write-to-read bypass and an
// integrated busy-bit scoreboard for RAW hazard detection at decode.
module reg_file_sb
  import riscv_rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRP    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_sb_if.slave  bus
);

  localparam int unsigned   AW = $clog2(NREG);
  localparam logic [AW-1:0] X0 = AW'(X0_IDX);

  // Flop array with reset so that every entry is cleared, not a RAM macro
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  logic [NRP-1:0][XLEN-1:0] rdata_c;
  logic [NRP-1:0]           rd_busy_c;

  always_comb begin
    mem_d = mem_q;
    if (bus.reg_wr && (bus.waddr != X0)) begin
      mem_d[bus.waddr] = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  always_comb begin
    rdata_c = '0;
    for (int p = 0; p < NRP; p++) begin
      if (bus.raddr[p] == X0) begin
        rdata_c[p] = '0;
      end else if ((BYPASS != 0) && bus.reg_wr && (bus.waddr == bus.raddr[p])) begin
        rdata_c[p] = bus.wdata;
      end else begin
        rdata_c[p] = mem_q[bus.raddr[p]];
      end
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .NRP    (NRP),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wr    (bus.reg_wr),
    .waddr     (bus.waddr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .raddr     (bus.raddr),
    .rd_busy   (rd_busy_c)
  );

  assign bus.rdata   = rdata_c;
  assign bus.rd_busy = rd_busy_c;
  assign bus.hazard  = |rd_busy_c;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default (BYPASS=1, NRP=2) and a BYPASS=0, NRP=3
// instance share one stimulus stream and are checked against one array model.
module tb_reg_file_sb;
  import riscv_rf_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRP(2)) bus_a ();
  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRP(3)) bus_b ();

  reg_file_sb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  reg_file_sb #(.XLEN(32), .NREG(32), .NRP(3), .BYPASS(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  typedef struct packed {
    logic [1:0][31:0] rd_a;
    logic [1:0]       bz_a;
    logic             hz_a;
    logic [2:0][31:0] rd_b;
    logic [2:0]       bz_b;
    logic             hz_b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_rd(input reg_idx_t a, input bit byp, input logic wr,
                                       input reg_idx_t wa, input logic [31:0] wd);
    if (a == 0) return '0;
    if (byp && wr && (wa == a)) return wd;
    return m_mem[a];
  endfunction

  function automatic logic m_bz(input reg_idx_t a, input bit byp, input logic wr,
                                input reg_idx_t wa);
    if (a == 0) return 1'b0;
    if (byp && wr && (wa == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic exp_t predict(input logic wr, input reg_idx_t wa, input logic [31:0] wd,
                                   input reg_idx_t ra0, input reg_idx_t ra1, input reg_idx_t ra2);
    exp_t e;
    reg_idx_t ra [3];
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    for (int p = 0; p < 2; p++) begin
      e.rd_a[p] = m_rd(ra[p], 1'b1, wr, wa, wd);
      e.bz_a[p] = m_bz(ra[p], 1'b1, wr, wa);
    end
    for (int p = 0; p < 3; p++) begin
      e.rd_b[p] = m_rd(ra[p], 1'b0, wr, wa, wd);
      e.bz_b[p] = m_bz(ra[p], 1'b0, wr, wa);
    end
    e.hz_a = |e.bz_a;
    e.hz_b = |e.bz_b;
    return e;
  endfunction

  // Clock-edge effect of one cycle of inputs on the architectural state
  function automatic void model_edge(input logic wr, input reg_idx_t wa, input logic [31:0] wd,
                                     input logic iv, input reg_idx_t ird, input logic fl);
    if (wr && (wa != 0)) m_mem[wa] = wd;
    for (int r = 1; r < 32; r++) begin
      if (fl)                          m_busy[r] = 1'b0;
      else if (iv && (ird == r))       m_busy[r] = 1'b1;
      else if (wr && (wa == r))        m_busy[r] = 1'b0;
    end
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a.rdata[%0d]", p), bus_a.rdata[p], e.rd_a[p]);
      chk($sformatf("a.rd_busy[%0d]", p), 32'(bus_a.rd_busy[p]), 32'(e.bz_a[p]));
    end
    chk("a.hazard", 32'(bus_a.hazard), 32'(e.hz_a));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("b.rdata[%0d]", p), bus_b.rdata[p], e.rd_b[p]);
      chk($sformatf("b.rd_busy[%0d]", p), 32'(bus_b.rd_busy[p]), 32'(e.bz_b[p]));
    end
    chk("b.hazard", 32'(bus_b.hazard), 32'(e.hz_b));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_all(e);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic wr, input reg_idx_t wa, input logic [31:0] wd,
                       input reg_idx_t ra0, input reg_idx_t ra1, input reg_idx_t ra2,
                       input logic iv, input reg_idx_t ird, input logic fl);
    bus_a.reg_wr = wr;  bus_b.reg_wr = wr;
    bus_a.waddr  = wa;  bus_b.waddr  = wa;
    bus_a.wdata  = wd;  bus_b.wdata  = wd;
    bus_a.raddr[0] = ra0; bus_a.raddr[1] = ra1;
    bus_b.raddr[0] = ra0; bus_b.raddr[1] = ra1; bus_b.raddr[2] = ra2;
    bus_a.iss_valid = iv; bus_b.iss_valid = iv;
    bus_a.iss_rd    = ird; bus_b.iss_rd   = ird;
    bus_a.flush     = fl; bus_b.flush     = fl;
  endtask

  // Called just after a rising edge; leaves the bench just after the next one
  task automatic step(input logic wr, input reg_idx_t wa, input logic [31:0] wd,
                      input reg_idx_t ra0, input reg_idx_t ra1, input reg_idx_t ra2,
                      input logic iv, input reg_idx_t ird, input logic fl);
    drive(wr, wa, wd, ra0, ra1, ra2, iv, ird, fl);
    exp_q.push_back(predict(wr, wa, wd, ra0, ra1, ra2));
    @(posedge clk);
    model_edge(wr, wa, wd, iv, ird, fl);
    #1;
  endtask

  task automatic read3(input reg_idx_t ra0, input reg_idx_t ra1, input reg_idx_t ra2);
    step(1'b0, 5'd0, 32'h0, ra0, ra1, ra2, 1'b0, 5'd0, 1'b0);
  endtask

  function automatic reg_idx_t pick_addr(input reg_idx_t wa, input reg_idx_t ird);
    int unsigned k;
    k = $urandom_range(0, 4);
    if (k == 0) return wa;
    if (k == 1) return ird;
    if (k == 2) return reg_idx_t'($urandom_range(0, 31));
    return reg_idx_t'($urandom_range(0, 7));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic        wr, iv, fl;
    reg_idx_t    wa, ird;
    logic [31:0] wd;
    int          wait_cyc;

    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 5'd31, 1'b0, 5'd0, 1'b0);
    #2;
    check_all(predict(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 5'd31));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After reset every register reads zero and nothing is busy
    for (int r = 1; r < 32; r += 3) begin
      read3(reg_idx_t'(r), reg_idx_t'(32 - r), reg_idx_t'(r + 1));
    end

    // Write with same-cycle bypass, then plain read
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    read3(5'd5, 5'd0, 5'd5);

    // x0 protection for both data and busy bit
    step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    read3(5'd0, 5'd0, 5'd0);

    // Issue to x7, observe busy, then writeback clears it
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
    read3(5'd7, 5'd1, 5'd7);
    step(1'b1, 5'd7, 32'hA5A5_0007, 5'd7, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
    read3(5'd7, 5'd1, 5'd7);

    // Same-cycle set and clear of x9 leaves it busy; flush then clears it
    step(1'b1, 5'd9, 32'h0000_0909, 5'd9, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 5'd9, 1'b1, 5'd3, 1'b1);
    read3(5'd9, 5'd3, 5'd9);

    // Write to x4 with every port reading x4: bypass vs stored value
    step(1'b1, 5'd4, 32'h1111_4444, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd4, 32'h2222_4444, 5'd4, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
    read3(5'd4, 5'd4, 5'd4);

    // Asynchronous reset mid-cycle with data stored and x3 busy
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 5'd3, 1'b1, 5'd3, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 5'd3, 1'b0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(predict(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 5'd3));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read3(5'd5, 5'd4, 5'd3);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 1) == 1);
      wa  = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31))
                                        : reg_idx_t'($urandom_range(0, 7));
      wd  = $urandom;
      iv  = ($urandom_range(0, 2) == 0);
      ird = reg_idx_t'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 24) == 0);
      step(wr, wa, wd, pick_addr(wa, ird), pick_addr(wa, ird), pick_addr(wa, ird), iv, ird, fl);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    wait_cyc = 0;
    while ((exp_q.size() != 0) && (wait_cyc < 10)) begin
      @(negedge clk);
      wait_cyc++;
    end
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated busy-bit scoreboard. It supersedes the fixed 32×32, two-read-port register file in the RISC-V core datapath. Width, depth and read-port count are generic, with optional write-to-read bypass. A per-register busy bit is set when an instruction claiming a destination issues and cleared on its writeback, so decode can detect RAW hazards directly from the register file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- NRP, 2, number of read ports
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = the read returns the stored value
- AW, $clog2(NREG), address width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_wr  in  1  write/writeback enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr  in  NRP×AW  read addresses, packed array [NRP-1:0]
- rdata  out  NRP×XLEN  read data, combinational
- rd_busy  out  NRP  per read port: source register has an outstanding producer
- hazard  out  1  OR of rd_busy
- iss_valid  in  1  an instruction issues this cycle with destination iss_rd
- iss_rd  in  AW  destination register of the issuing instruction
- flush  in  1  synchronous clear of all busy bits (pipeline flush)

## Operation
- Register 0 reads as 0. Writes to register 0 are dropped. Register 0 is never busy.
- Read data, per port p:
  - raddr[p]==0 → 0.
  - Else if BYPASS and reg_wr and waddr==raddr[p] → wdata.
  - Else → stored value.
- Write: at the clock edge, if reg_wr and waddr≠0, the addressed entry takes wdata.
- Busy-bit next state for register r≠0, in priority order:
  1. flush → 0.
  2. iss_valid and iss_rd==r → 1.
  3. reg_wr and waddr==r → 0.
  4. Otherwise hold.
- A set and a clear of the same register in one cycle leave the bit set (the new producer wins).
- rd_busy[p] = busy[raddr[p]], except:
  - 0 when raddr[p]==0;
  - 0 when BYPASS and reg_wr and waddr==raddr[p], because the value is being forwarded this cycle.
- rd_busy does not see a same-cycle iss_valid; the new busy bit is visible from the next cycle.
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0. With inputs idle, every rdata, rd_busy and hazard output is therefore 0.
- Reset asserted mid-operation discards pending busy bits and written data immediately. There is no partial-write state.

## Timing
- Read latency 0 (combinational from raddr, reg_wr, waddr, wdata and the state).
- Write latency 1: the value is visible through the non-bypass path on the cycle after the write edge.
- Busy set/clear latency 1 edge. Flush takes effect at the next edge.
- rst_n is asserted asynchronously; release is assumed synchronised upstream.
- No backpressure. Every input is sampled every cycle.

## Structure
- Shared package riscv_rf_pkg holds:
  - default XLEN and NREG constants;
  - the register-index typedef;
  - a localparam for the x0 index.
- Sub-module rf_scoreboard contains the NREG-bit busy vector, its set/clear/flush logic and the rd_busy generation.
- reg_file_sb instantiates rf_scoreboard and holds the storage array and the read/bypass muxes.
- Storage is a flop array with no reset-less RAM inference, so that clear-on-reset holds.

## Test plan
- Reset: pulse rst_n low asynchronously mid-cycle → all rdata 0 and hazard 0 immediately. After release, reads of x1..x31 return 0.
- Write/read with BYPASS=1: in the same cycle, reg_wr=1, waddr=5, wdata=0xDEADBEEF, raddr[0]=5 → rdata[0]=0xDEADBEEF that cycle and on the following cycle with reg_wr=0.
- x0 protection: write 0x12345678 to waddr=0 → raddr=0 returns 0. iss_rd=0 never raises rd_busy.
- Scoreboard: iss_valid, iss_rd=7 → next cycle rd_busy=1 and hazard=1 for raddr=7. Writeback to waddr=7 → rd_busy=0 in that same cycle (bypass), and the busy bit is cleared after the edge.
- Simultaneous set and clear: iss_valid with iss_rd=9 and reg_wr with waddr=9 in one cycle → busy[9]=1 after the edge. flush the next cycle → busy all 0.
- BYPASS=0 and NRP=3 configuration: same-cycle write to 4 with raddr=4 on all ports → old value on all three ports. New value appears on the next cycle.
